post_main: RTL and testbench

Post-processing stage of the pipelined modular multiplier, sitting at the output end of the multiplier core and undoing the operand normalization applied at its input. Each frame it samples a normalized result, right-shifts it by N−k with a multi-cycle logarithmic shifter (one barrel stage per cycle), applies one conditional modulus subtraction, and presents the reduced result with a one-cycle `done` pulse. The frame length is a fixed N_CYCLES clocks, so it runs in lockstep with the other pipeline stages.

---
 rtl/post_main.sv | 115 +++++++++++
 tb/tb_post_main.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/post_main.sv
// Output stage of the pipelined modular multiplier: de-normalizes the core result
// with a one-stage-per-cycle log shifter, does one conditional modulus subtraction,
// and completes a frame exactly every N_CYCLES clocks.
//
// state  | meaning
// START  | sample operands, compute shift amount, arm frame counter
// SHIFT  | one barrel stage per cycle, stage j shifts by 2^j when s[j] is set
// SUB    | single conditional subtraction of the modulus
// WAIT   | pad to the fixed frame length, publish result when the counter hits 0
module post_main #(
  parameter int N        = 512,
  parameter int N_CYCLES = N + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          in_c,
  input  logic [N-1:0]          in_m,
  input  logic [$clog2(N):0]    in_k,
  output logic [N-1:0]          out_c,
  output logic [$clog2(N):0]    out_k,
  output logic                  done
);

  localparam int LOGN = $clog2(N);
  localparam int JW   = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int IW   = $clog2(N_CYCLES);

  localparam logic [3:0] ST_START = 4'b0001;
  localparam logic [3:0] ST_SHIFT = 4'b0010;
  localparam logic [3:0] ST_SUB   = 4'b0100;
  localparam logic [3:0] ST_WAIT  = 4'b1000;

  localparam logic [JW-1:0] J_LAST  = JW'(LOGN - 1);
  localparam logic [IW-1:0] I_START = IW'(N_CYCLES - 2);

  if (N < 4 || (1 << LOGN) != N || N_CYCLES < LOGN + 3) begin : g_param_check
    $error("post_main: N must be a power of two >= 4 and N_CYCLES >= LOGN+3");
  end

  logic [3:0]      state;
  logic [N-1:0]    c;
  logic [N-1:0]    m;
  logic [LOGN:0]   k_s;
  logic [LOGN-1:0] s;
  logic [JW-1:0]   j;
  logic [IW-1:0]   i;

  logic [N-1:0]    c_shift;
  logic [LOGN-1:0] s_init;

  // k = N and k = 0 both wrap to a zero shift once truncated to LOGN bits
  assign s_init = LOGN'(N - int'(in_k));

  always_comb begin
    c_shift = c;
    for (int g = 0; g < LOGN; g++) begin
      if (j == JW'(g)) c_shift = c >> (2 ** g);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_START;
      c     <= '0;
      m     <= '0;
      k_s   <= '0;
      s     <= '0;
      j     <= '0;
      i     <= '0;
      out_c <= '0;
      out_k <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          c     <= in_c;
          m     <= in_m;
          k_s   <= in_k;
          s     <= s_init;
          j     <= '0;
          i     <= I_START;
          done  <= 1'b0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (s[j]) c <= c_shift;
          j <= j + JW'(1);
          i <= i - IW'(1);
          if (j == J_LAST) state <= ST_SUB;
        end
        ST_SUB: begin
          // a single subtraction only; values >= 2m leave partially reduced
          if (c >= m) c <= c - m;
          i     <= i - IW'(1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i == '0) begin
            out_c <= c;
            out_k <= k_s;
            done  <= 1'b1;
            state <= ST_START;
          end else begin
            i <= i - IW'(1);
          end
        end
        default: begin
          done  <= 1'b0;
          state <= ST_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_post_main.sv
// Self-checking bench for post_main at N=16: directed vectors, back-to-back frames,
// asynchronous reset cases and a randomized sweep against an arithmetic model.
module tb_post_main;

  localparam int N  = 16;
  localparam int NC = 17;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_c  = '0;
  logic [15:0] in_m  = '0;
  logic [4:0]  in_k  = '0;
  logic [15:0] out_c;
  logic [4:0]  out_k;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  post_main #(.N(N), .N_CYCLES(NC)) dut (
    .clock(clock),
    .reset(reset),
    .in_c (in_c),
    .in_m (in_m),
    .in_k (in_k),
    .out_c(out_c),
    .out_k(out_k),
    .done (done)
  );

  always #5 clock = ~clock;

  // de-normalize by N-k, then at most one subtraction of m
  function automatic logic [15:0] model(input logic [15:0] c, input logic [15:0] m, input int k);
    int s;
    int v;
    s = (N - k) % N;
    v = int'(c) >> s;
    if (v >= int'(m)) v = v - int'(m);
    return 16'(v);
  endfunction

  // Called at a negedge while the DUT sits in START; returns at the negedge where done is high.
  task automatic do_frame(input logic [15:0] c, input logic [15:0] m, input logic [4:0] k,
                          output int cyc, output logic stable);
    logic [15:0] held;
    in_c = c; in_m = m; in_k = k;
    cyc = -1; stable = 1'b1; held = out_c;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clock);
      if (t == 1) begin
        #1;
        in_c = 16'($urandom); in_m = 16'($urandom); in_k = 5'($urandom);
      end
      @(negedge clock);
      if (done) begin
        cyc = t;
        break;
      end
      if (out_c !== held) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (out_c !== 16'h0) begin n_fail++; $display("FAIL reset_out_c got %h want 0000", out_c); end
    n_checks++; if (out_k !== 5'd0)  begin n_fail++; $display("FAIL reset_out_k got %0d want 0", out_k); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    logic [15:0] vc [5] = '{16'h0003, 16'h0003, 16'h8000, 16'h3800, 16'h2D00};
    logic [15:0] vm [5] = '{16'h0007, 16'h0007, 16'h0001, 16'h0005, 16'd30};
    logic [4:0]  vk [5] = '{5'd16,    5'd0,     5'd1,     5'd5,     5'd8};
    logic [15:0] ve [5] = '{16'h0003, 16'h0003, 16'h0000, 16'h0002, 16'd15};
    int cyc;
    logic stable;
    for (int n = 0; n < 5; n++) begin
      do_frame(vc[n], vm[n], vk[n], cyc, stable);
      n_checks++; if (cyc != NC) begin n_fail++; $display("FAIL vec%0d_latency got %0d want %0d", n, cyc, NC); end
      n_checks++; if (out_c !== ve[n]) begin n_fail++; $display("FAIL vec%0d_out_c got %h want %h", n, out_c, ve[n]); end
      n_checks++; if (out_k !== vk[n]) begin n_fail++; $display("FAIL vec%0d_out_k got %0d want %0d", n, out_k, vk[n]); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic stable;
    logic [15:0] c, m, exp;
    logic [4:0] k;
    for (int n = 0; n < 4; n++) begin
      c = 16'($urandom); m = 16'($urandom_range(1, 200)); k = 5'($urandom_range(0, 16));
      exp = model(c, m, int'(k));
      do_frame(c, m, k, cyc, stable);
      n_checks++; if (cyc != NC) begin n_fail++; $display("FAIL b2b%0d_spacing got %0d want %0d", n, cyc, NC); end
      n_checks++; if (out_c !== exp) begin n_fail++; $display("FAIL b2b%0d_out_c got %h want %h", n, out_c, exp); end
      n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_stable got %b want 1", n, stable); end
    end
  endtask

  task automatic test_mid_reset;
    int cyc;
    logic stable;
    do_frame(16'h3800, 16'h0005, 5'd5, cyc, stable);
    in_c = 16'h3800; in_m = 16'h0005; in_k = 5'd5;
    repeat (6) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_c !== 16'h0) begin n_fail++; $display("FAIL midrst_out_c got %h want 0000", out_c); end
    n_checks++; if (out_k !== 5'd0)  begin n_fail++; $display("FAIL midrst_out_k got %0d want 0", out_k); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    do_frame(16'h2D00, 16'd30, 5'd8, cyc, stable);
    n_checks++; if (cyc != NC) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", cyc, NC); end
    n_checks++; if (out_c !== 16'd15) begin n_fail++; $display("FAIL midrst_out_c_after got %h want 000f", out_c); end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL midrst_no_early_done got %b want 1", stable); end
  endtask

  task automatic test_reset_vs_done;
    int cyc;
    logic stable;
    do_frame(16'h0003, 16'h0007, 5'd16, cyc, stable);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rvd_done_before got %b want 1", done); end
    reset = 1'b1;
    #1;
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL rvd_done got %b want 0", done); end
    n_checks++; if (out_c !== 16'h0) begin n_fail++; $display("FAIL rvd_out_c got %h want 0000", out_c); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random;
    int cyc, k, s, m, x, xmax;
    logic stable;
    logic [15:0] exp;
    for (int n = 0; n < 1000; n++) begin
      k = $urandom_range(1, 16);
      s = (N - k) % N;
      m = $urandom_range(1, (1 << k) - 1);
      xmax = (2 * m < (1 << k)) ? 2 * m - 1 : (1 << k) - 1;
      x = $urandom_range(0, xmax);
      exp = 16'(x % m);
      do_frame(16'(x << s), 16'(m), 5'(k), cyc, stable);
      n_checks++; if (cyc != NC) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", n, cyc, NC); end
      n_checks++; if (out_c !== exp) begin n_fail++; $display("FAIL rnd%0d_out_c got %h want %h (k=%0d m=%0d x=%0d)", n, out_c, exp, k, m, x); end
      n_checks++; if (out_k !== 5'(k)) begin n_fail++; $display("FAIL rnd%0d_out_k got %0d want %0d", n, out_k, k); end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    test_reset_vs_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
